// File: rtl/semaphore_phase_timer.sv
// Phase timer for the semaphore control unit.
// Latches the duration of the phase selected by TimerMux and counts it down in seconds
// derived from a clock prescaler. At expiry it issues a one-cycle trigger pulse.
// Optional feature macro: SEMAPHORE_PED_REQ_EN (pedestrian request shortens green phases).
module semaphore_phase_timer #(
    parameter int unsigned PRESCALE  = 50000000,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned T_PGREEN  = 30,
    parameter int unsigned T_SGREEN  = 20,
    parameter int unsigned T_YELLOW  = 4,
    parameter int unsigned T_PED_MIN = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       TimerMux,
    output logic             trigger,
    output logic [CNT_W-1:0] remaining,
    output logic             tick,
    input  logic             ped_request,
    output logic             ped_pending
);

    // Truncate to the counter width, then force zero to one so a phase always lasts.
    function automatic logic [CNT_W-1:0] dur_clamp(input int unsigned t);
        logic [CNT_W-1:0] v;
        v = CNT_W'(t);
        if (v == '0) v = CNT_W'(1);
        return v;
    endfunction

    localparam logic [CNT_W-1:0] DUR_P   = dur_clamp(T_PGREEN);
    localparam logic [CNT_W-1:0] DUR_S   = dur_clamp(T_SGREEN);
    localparam logic [CNT_W-1:0] DUR_Y   = dur_clamp(T_YELLOW);
    localparam logic [CNT_W-1:0] PED_MIN = dur_clamp(T_PED_MIN);

    localparam int unsigned      PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);

    function automatic logic [CNT_W-1:0] dur_sel(input logic [1:0] sel);
        case (sel)
            2'b00:   return DUR_P;
            2'b01:   return DUR_S;
            default: return DUR_Y;
        endcase
    endfunction

    typedef enum logic [1:0] {StLoad, StCount, StFire} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             tick_q, tick_d;
    logic             trig_q, trig_d;

`ifdef SEMAPHORE_PED_REQ_EN
    logic       ped_s1_q, ped_s2_q, ped_prev_q;
    logic       ped_pending_q, ped_pending_d;
    logic [1:0] phase_q;
`endif

    // Next-state logic: load duration, count seconds, fire trigger.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        rem_d   = rem_q;
        tick_d  = 1'b0;
        trig_d  = 1'b0;
        unique case (state_q)
            StLoad: begin
                rem_d   = dur_sel(TimerMux);
                presc_d = '0;
                state_d = StCount;
            end
            StCount: begin
                if (enable) begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        rem_d   = rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_d = StFire;
                            trig_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
`ifdef SEMAPHORE_PED_REQ_EN
                    // Shortening wins over a coincident tick; PED_MIN >= 1 keeps us in COUNT.
                    if (ped_pending_q && !phase_q[1] && (rem_q > PED_MIN)) begin
                        rem_d = PED_MIN;
                    end
`endif
                end
            end
            StFire: begin
                state_d = StLoad;
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    // Timer state and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StLoad;
            presc_q <= '0;
            rem_q   <= '0;
            tick_q  <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            rem_q   <= rem_d;
            tick_q  <= tick_d;
            trig_q  <= trig_d;
        end
    end

    assign trigger   = trig_q;
    assign tick      = tick_q;
    assign remaining = rem_q;

`ifdef SEMAPHORE_PED_REQ_EN
    // Pending flag: set on a synchronized rising edge, cleared when a yellow phase loads.
    always_comb begin
        ped_pending_d = ped_pending_q;
        if (state_q == StLoad && TimerMux[1]) ped_pending_d = 1'b0;
        if (ped_s2_q && !ped_prev_q) ped_pending_d = 1'b1;
    end

    // Button synchronizer, edge history, pending flag and latched phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ped_s1_q      <= 1'b0;
            ped_s2_q      <= 1'b0;
            ped_prev_q    <= 1'b0;
            ped_pending_q <= 1'b0;
            phase_q       <= 2'b00;
        end else begin
            ped_s1_q      <= ped_request;
            ped_s2_q      <= ped_s1_q;
            ped_prev_q    <= ped_s2_q;
            ped_pending_q <= ped_pending_d;
            if (state_q == StLoad) phase_q <= TimerMux;
        end
    end

    assign ped_pending = ped_pending_q;
`else
    logic unused_ped;
    assign unused_ped  = ped_request;
    assign ped_pending = 1'b0;
`endif

endmodule
